kf8259_in_service_control: RTL and testbench

- Stage directly downstream of the 8259 request latch. Consumes the latched interrupt request register (IRR) and resolves priority against the in-service register (ISR).
- Drives the INT output and runs the two-pulse 8086-mode INTA handshake. Supplies the vector byte and handles EOI, auto-EOI and priority rotation.
- Feeds back freeze and one-hot clear_interrupt_request to the request latch.

---
 rtl/kf8259_common_pkg.sv | 27 ++
 rtl/kf8259_priority_resolver.sv | 23 ++
 rtl/kf8259_in_service_control.sv | 92 +++++++++
 tb/tb_kf8259_in_service_control.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/kf8259_common_pkg.sv
// kf8259_common_pkg: shared state encoding and priority helpers for the 8259 in-service stage.
package kf8259_common_pkg;
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  typedef struct packed {
    logic       valid;
    logic [2:0] level;
  } resolved_t;
  function automatic logic [7:0] rotate_right8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} >> n;
    return d[7:0];
  endfunction
  function automatic logic [7:0] rotate_left8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction
  // Lowest set bit index wins.
  function automatic resolved_t resolve_highest(input logic [7:0] v);
    resolved_t r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) r = '{valid: 1'b1, level: 3'(i)};
    return r;
  endfunction
endpackage

// File: rtl/kf8259_priority_resolver.sv
// kf8259_priority_resolver: fully nested priority check of IRR against ISR under a rotating pointer.
module kf8259_priority_resolver
  import kf8259_common_pkg::*;
(
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] in_service_register,
  input  logic [2:0] priority_pointer,
  output logic       eligible,
  output logic [2:0] level,
  output logic [2:0] highest_isr_level,
  output logic       highest_isr_valid
);
  logic [2:0] shift;
  resolved_t  irr_top, isr_top;
  // Rotating by pointer+1 puts the rank-0 level at bit 0.
  assign shift             = priority_pointer + 3'd1;
  assign irr_top           = resolve_highest(rotate_right8(interrupt_request_register, shift));
  assign isr_top           = resolve_highest(rotate_right8(in_service_register, shift));
  assign eligible          = irr_top.valid & (~isr_top.valid | (irr_top.level < isr_top.level));
  assign level             = irr_top.level + shift;
  assign highest_isr_level = isr_top.level + shift;
  assign highest_isr_valid = isr_top.valid;
endmodule

// File: rtl/kf8259_in_service_control.sv
// kf8259_in_service_control: ISR, INT generation, two-pulse INTA handshake, vector output and EOI handling.
module kf8259_in_service_control
  import kf8259_common_pkg::*;
#(
  parameter logic [2:0] RESET_PRIORITY_POINTER = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request_register,
  input  logic       interrupt_acknowledge_n,
  input  logic       non_specific_eoi,
  input  logic       specific_eoi,
  input  logic [2:0] eoi_level,
  input  logic       auto_eoi_config,
  input  logic       rotate_on_eoi,
  input  logic [4:0] vector_base,
  output logic       interrupt_out,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_out_enable
);
  state_t     state, state_next;
  logic [2:0] pointer, pointer_next, level_q, level_next, level, highest_isr_level, eoi_target;
  logic       inta_prev, spurious, spurious_next, eligible, highest_isr_valid;
  logic       fall, rise, ack, aeoi, eoi_valid;
  logic [7:0] eoi_mask, ack_mask, aeoi_mask, isr_next, vector_next;
  logic       int_next, freeze_next, ven_next;
  kf8259_priority_resolver resolver (
    .interrupt_request_register(interrupt_request_register),
    .in_service_register       (in_service_register),
    .priority_pointer          (pointer),
    .eligible                  (eligible),
    .level                     (level),
    .highest_isr_level         (highest_isr_level),
    .highest_isr_valid         (highest_isr_valid)
  );
  always_comb begin
    fall          = inta_prev & ~interrupt_acknowledge_n;
    rise          = ~inta_prev & interrupt_acknowledge_n;
    eoi_valid     = specific_eoi ? in_service_register[eoi_level] : (non_specific_eoi & highest_isr_valid);
    eoi_target    = specific_eoi ? eoi_level : highest_isr_level;
    eoi_mask      = eoi_valid ? 8'd1 << eoi_target : 8'd0;
    ack           = (state == IDLE) & fall;
    ack_mask      = (ack & eligible) ? 8'd1 << level : 8'd0;
    aeoi          = (state == ACK2) & rise & auto_eoi_config & ~spurious;
    aeoi_mask     = aeoi ? 8'd1 << level_q : 8'd0;
    // EOI clear lands before the acknowledge set, so a same-bit collision leaves the bit set.
    isr_next      = ((in_service_register & ~eoi_mask) | ack_mask) & ~aeoi_mask;
    pointer_next  = (aeoi & rotate_on_eoi) ? level_q : (eoi_valid & rotate_on_eoi) ? eoi_target : pointer;
    level_next    = ack ? (eligible ? level : SPURIOUS_LEVEL) : level_q;
    spurious_next = ack ? ~eligible : spurious;
    int_next      = (state == IDLE) & ~fall & eligible;
    freeze_next   = (state == IDLE) ? fall : ~((state == ACK2) & rise);
    vector_next   = ((state == WAIT2) & fall) ? {vector_base, level_q} : vector_out;
    ven_next      = ((state == WAIT2) & fall) | ((state == ACK2) & ~interrupt_acknowledge_n);
    state_next    = state;
    case (state)
      IDLE:    state_next = fall ? ACK1 : IDLE;
      ACK1:    state_next = rise ? WAIT2 : ACK1;
      WAIT2:   state_next = fall ? ACK2 : WAIT2;
      default: state_next = rise ? IDLE : ACK2;
    endcase
  end
  always_ff @(negedge clock or negedge reset_n)
    if (!reset_n) begin
      state                   <= IDLE;
      pointer                 <= RESET_PRIORITY_POINTER;
      level_q                 <= SPURIOUS_LEVEL;
      spurious                <= 1'b0;
      inta_prev               <= 1'b1;
      in_service_register     <= 8'd0;
      interrupt_out           <= 1'b0;
      freeze                  <= 1'b0;
      clear_interrupt_request <= 8'd0;
      vector_out              <= 8'd0;
      vector_out_enable       <= 1'b0;
    end else begin
      state                   <= state_next;
      pointer                 <= pointer_next;
      level_q                 <= level_next;
      spurious                <= spurious_next;
      inta_prev               <= interrupt_acknowledge_n;
      in_service_register     <= isr_next;
      interrupt_out           <= int_next;
      freeze                  <= freeze_next;
      clear_interrupt_request <= ack_mask;
      vector_out              <= vector_next;
      vector_out_enable       <= ven_next;
    end
endmodule

// File: tb/tb_kf8259_in_service_control.sv
// tb_kf8259_in_service_control: directed bench with a rank-based reference model checked every cycle.
module tb_kf8259_in_service_control;
  logic       clock = 0, reset_n = 0, inta_n = 1, nseoi = 0, seoi = 0, aeoi = 0, rot = 0;
  logic [7:0] irr = 0;
  logic [2:0] eoi_lvl = 0;
  logic [4:0] vbase = 5'h08;
  logic       int_o, frz, ven;
  logic [7:0] clr, isr, vec;
  int         vectors = 0, miscompares = 0;
  bit         cmp_on = 0;
  kf8259_in_service_control dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .interrupt_request_register(irr),
    .interrupt_acknowledge_n   (inta_n),
    .non_specific_eoi          (nseoi),
    .specific_eoi              (seoi),
    .eoi_level                 (eoi_lvl),
    .auto_eoi_config           (aeoi),
    .rotate_on_eoi             (rot),
    .vector_base               (vbase),
    .interrupt_out             (int_o),
    .freeze                    (frz),
    .clear_interrupt_request   (clr),
    .in_service_register       (isr),
    .vector_out                (vec),
    .vector_out_enable         (ven)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: levels ranked by (level - pointer - 1) mod 8, handshake tracked as INTA pulse phases.
  logic [7:0] m_isr, m_clr, m_vec;
  logic       m_int, m_frz, m_ven, m_prev, m_spur, m_elig, m_fall, m_rise;
  int         m_ptr, m_phase, m_lvl, m_best, m_isr_rank, m_top, m_cleared;
  function automatic int rank(input int l, input int p);
    return (l - p - 1) & 7;
  endfunction
  always @(negedge clock or negedge reset_n)
    if (!reset_n) begin
      m_isr = 0; m_ptr = 7; m_prev = 1; m_phase = 0; m_lvl = 7; m_spur = 0;
      m_int = 0; m_frz = 0; m_clr = 0; m_vec = 0; m_ven = 0;
    end else begin
      m_best = -1; m_isr_rank = 8; m_top = -1; m_cleared = -1;
      for (int l = 0; l < 8; l++) begin
        if (irr[l] && (m_best < 0 || rank(l, m_ptr) < rank(m_best, m_ptr))) m_best = l;
        if (m_isr[l] && rank(l, m_ptr) < m_isr_rank) begin m_isr_rank = rank(l, m_ptr); m_top = l; end
      end
      m_elig = m_best >= 0 && rank(m_best, m_ptr) < m_isr_rank;
      m_fall = m_prev && !inta_n;
      m_rise = !m_prev && inta_n;
      if (seoi) begin
        if (m_isr[eoi_lvl]) m_cleared = int'(eoi_lvl);
      end else if (nseoi && m_top >= 0) m_cleared = m_top;
      if (m_cleared >= 0) begin
        m_isr[m_cleared] = 0;
        if (rot) m_ptr = m_cleared;
      end
      m_clr = 0; m_int = 0;
      case (m_phase)
        0: if (m_fall) begin
             m_phase = 1; m_frz = 1; m_spur = !m_elig; m_lvl = m_elig ? m_best : 7;
             if (m_elig) begin m_isr[m_best] = 1; m_clr = 8'd1 << m_best; end
           end else m_int = m_elig;
        1: if (m_rise) m_phase = 2;
        2: if (m_fall) begin m_phase = 3; m_vec = {vbase, m_lvl[2:0]}; m_ven = 1; end
        default: if (m_rise) begin
             m_phase = 0; m_frz = 0; m_ven = 0;
             if (aeoi && !m_spur) begin m_isr[m_lvl] = 0; if (rot) m_ptr = m_lvl; end
           end
      endcase
      m_prev = inta_n;
    end
  always @(posedge clock)
    if (cmp_on) begin
      check("model_int", {7'd0, int_o}, {7'd0, m_int});
      check("model_freeze", {7'd0, frz}, {7'd0, m_frz});
      check("model_clear", clr, m_clr);
      check("model_isr", isr, m_isr);
      check("model_vector", vec, m_vec);
      check("model_ven", {7'd0, ven}, {7'd0, m_ven});
    end
  task automatic acknowledge(input logic [7:0] exp_clr, input logic [7:0] exp_vec);
    inta_n = 0;
    @(posedge clock);
    check("ack_clear", clr, exp_clr);
    check("ack_freeze", {7'd0, frz}, 8'd1);
    irr = irr & ~exp_clr;
    @(posedge clock);
    check("ack_clear_once", clr, 8'd0);
    inta_n = 1;
    repeat (2) @(posedge clock);
    check("wait2_freeze", {7'd0, frz}, 8'd1);
    inta_n = 0;
    @(posedge clock);
    check("ack2_vector", vec, exp_vec);
    check("ack2_ven", {7'd0, ven}, 8'd1);
    @(posedge clock);
    inta_n = 1;
    @(posedge clock);
    check("end_ven", {7'd0, ven}, 8'd0);
    check("end_freeze", {7'd0, frz}, 8'd0);
    @(posedge clock);
  endtask
  task automatic pulse_eoi(input logic spec, input logic [2:0] lvl);
    seoi = spec; nseoi = !spec; eoi_lvl = lvl;
    @(posedge clock);
    seoi = 0; nseoi = 0;
    @(posedge clock);
  endtask
  initial begin
    repeat (3) @(posedge clock);
    check("reset_int", {7'd0, int_o}, 8'd0);
    check("reset_isr", isr, 8'd0);
    check("reset_vector", vec, 8'd0);
    reset_n = 1;
    cmp_on = 1;
    @(posedge clock);
    irr = 8'h04;
    @(posedge clock);
    check("int_one_clock", {7'd0, int_o}, 8'd1);
    acknowledge(8'h04, 8'h42);
    check("isr_after_ir2", isr, 8'h04);
    irr = 8'h10;
    repeat (2) @(posedge clock);
    check("masked_by_isr", {7'd0, int_o}, 8'd0);
    irr = 8'h11;
    @(posedge clock);
    check("nested_int", {7'd0, int_o}, 8'd1);
    acknowledge(8'h01, 8'h40);
    check("isr_nested", isr, 8'h05);
    irr = 0;
    pulse_eoi(0, 3'd0);
    check("nonspecific_eoi", isr, 8'h04);
    pulse_eoi(1, 3'd2);
    check("specific_eoi", isr, 8'h00);
    aeoi = 1; rot = 1; irr = 8'h08;
    @(posedge clock);
    acknowledge(8'h08, 8'h43);
    check("aeoi_isr", isr, 8'h00);
    irr = 8'h18;
    @(posedge clock);
    acknowledge(8'h10, 8'h44);
    @(posedge clock);
    acknowledge(8'h08, 8'h43);
    aeoi = 0; rot = 0;
    irr = 8'h02;
    @(posedge clock);
    acknowledge(8'h02, 8'h41);
    irr = 8'h01;
    @(posedge clock);
    check("rotated_int", {7'd0, int_o}, 8'd1);
    irr = 0;
    acknowledge(8'h00, 8'h47);
    check("spurious_isr", isr, 8'h02);
    irr = 8'h20;
    @(posedge clock);
    inta_n = 0;
    @(posedge clock);
    inta_n = 1;
    repeat (2) @(posedge clock);
    #2 reset_n = 0; irr = 0;
    #1;
    check("rst_freeze", {7'd0, frz}, 8'd0);
    check("rst_isr", isr, 8'd0);
    check("rst_ven", {7'd0, ven}, 8'd0);
    @(posedge clock);
    reset_n = 1; irr = 8'h02;
    @(posedge clock);
    check("post_rst_int", {7'd0, int_o}, 8'd1);
    acknowledge(8'h02, 8'h41);
    check("post_rst_isr", isr, 8'h02);
    pulse_eoi(0, 3'd0);
    check("final_isr", isr, 8'h00);
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
